// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multicycle RV32I controller.
// The controller uses master; the datapath and memory side use slave.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_load;
  logic             pc_write;
  logic             pc_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       aluop;
  logic [3:0]       ctrl_code;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [CNT_W-1:0] retired;
  logic             fault;
  logic [1:0]       fault_cause;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, iord, ir_load, pc_write, pc_src, alu_src_a, alu_src_b, aluop,
           ctrl_code, reg_write, result_src, retired, fault, fault_cause
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_load, pc_write, pc_src, alu_src_a, alu_src_b, aluop,
           ctrl_code, reg_write, result_src, retired, fault, fault_cause
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences memory, ALU, PC, IR and
// register file, counts retired instructions and latches a sticky fault.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr,
    StExecR, StExecI, StAluWb, StBranch, StJal, StFault
  } state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q;
  logic             fault_q;
  logic [1:0]       cause_q, cause_d;
  logic             retire;
  logic             mem_wait;
  logic             tmo_hit;

  assign mem_wait = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr)) &&
                    !bus.mem_ready;
  assign tmo_hit  = mem_wait && (tmo_q == TmoLast);
  assign tmo_d    = mem_wait ? tmo_q + 16'd1 : 16'd0;

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    retire         = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_load    = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.aluop      = 2'b00;
    bus.ctrl_code  = 4'b0000;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;

    unique case (state_q)
      StFetch: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_load  = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = StDecode;
        end else if (tmo_hit) begin
          state_d = StFault;
          cause_d = 2'b10;
        end
      end
      StDecode: begin
        // Speculatively form the branch/jal target into ALUOut.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        case (bus.instr[6:0])
          7'b0000011, 7'b0100011: state_d = StMemAddr;
          7'b0110011:             state_d = StExecR;
          7'b0010011:             state_d = StExecI;
          7'b1100011:             state_d = StBranch;
          7'b1101111:             state_d = StJal;
          default: begin
            state_d = StFault;
            cause_d = 2'b01;
          end
        endcase
      end
      StMemAddr: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b10;
        state_d       = bus.instr[5] ? StMemWr : StMemRd;
      end
      StMemRd: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          state_d = StMemWb;
        end else if (tmo_hit) begin
          state_d = StFault;
          cause_d = 2'b10;
        end
      end
      StMemWb: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 2'b01;
        retire         = 1'b1;
        state_d        = StFetch;
      end
      StMemWr: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (tmo_hit) begin
          state_d = StFault;
          cause_d = 2'b10;
        end
      end
      StExecR: begin
        bus.alu_src_a = 2'b10;
        bus.aluop     = 2'b10;
        bus.ctrl_code = {bus.instr[30], bus.instr[14:12]};
        state_d       = StAluWb;
      end
      StExecI: begin
        // instr[30] is immediate data here, so addi must never decode as sub.
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b10;
        bus.aluop     = 2'b10;
        bus.ctrl_code = {1'b0, bus.instr[14:12]};
        state_d       = StAluWb;
      end
      StAluWb: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        bus.alu_src_a = 2'b10;
        bus.aluop     = 2'b01;
        bus.pc_src    = 1'b1;
        case (bus.instr[14:12])
          3'b000: begin
            bus.pc_write = bus.zero;
            retire       = 1'b1;
            state_d      = StFetch;
          end
          3'b001: begin
            bus.pc_write = !bus.zero;
            retire       = 1'b1;
            state_d      = StFetch;
          end
          default: begin
            state_d = StFault;
            cause_d = 2'b01;
          end
        endcase
      end
      StJal: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 2'b10;
        bus.pc_write   = 1'b1;
        bus.pc_src     = 1'b1;
        retire         = 1'b1;
        state_d        = StFetch;
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase

    // Reset abandons any transaction without issuing side effects.
    if (rst) begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.ir_load   = 1'b0;
      bus.pc_write  = 1'b0;
      bus.reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      tmo_q     <= 16'd0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_q + CNT_W'(retire);
      fault_q   <= fault_q | (state_d == StFault);
      cause_q   <= cause_d;
    end
  end

  assign bus.retired     = retired_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction step-plan model checked every cycle,
// directed scenarios with literal expectations, then randomized instructions and stalls.
module tb_multicycle_control;
  localparam int unsigned TMO   = 4;
  localparam int unsigned CNT_W = 6;

  localparam logic [31:0] AddiW = 32'h00500093;
  localparam logic [31:0] SubW  = 32'h402081B3;
  localparam logic [31:0] SraiW = 32'h4050D093;
  localparam logic [31:0] LwW   = 32'h0000A183;
  localparam logic [31:0] SwW   = 32'h0020A023;
  localparam logic [31:0] BeqW  = 32'h00000063;
  localparam logic [31:0] BneW  = 32'h00001063;
  localparam logic [31:0] BadW  = 32'h0000007F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       req, we, iord, irl, pcw, pcs;
    logic [1:0] a, b, op;
    logic [3:0] cc;
    logic       rw;
    logic [1:0] rs;
  } exp_t;

  // One entry per cycle-step the instruction needs; mem steps repeat until mem_ready.
  typedef struct packed {
    logic fetch, mem, br, retire, die;
    exp_t o;
  } step_t;

  step_t            plan[$];
  logic             m_fault;
  logic [1:0]       m_cause;
  logic [CNT_W-1:0] m_ret;
  int unsigned      m_wait;
  logic             use_dir;
  logic [31:0]      dir_instr;
  logic             run = 1'b0;
  int               n_chk = 0;
  int               n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic build_plan(input logic [31:0] w);
    step_t s;
    plan.delete();
    s = '0; s.fetch = 1'b1; s.mem = 1'b1; s.o.req = 1'b1; s.o.b = 2'b01;
    plan.push_back(s);
    s = '0; s.o.a = 2'b01; s.o.b = 2'b10;
    case (w[6:0])
      7'b0000011, 7'b0100011: begin
        plan.push_back(s);
        s = '0; s.o.a = 2'b10; s.o.b = 2'b10;
        plan.push_back(s);
        s = '0; s.mem = 1'b1; s.o.req = 1'b1; s.o.iord = 1'b1;
        if (w[5]) begin
          s.o.we = 1'b1; s.retire = 1'b1;
          plan.push_back(s);
        end else begin
          plan.push_back(s);
          s = '0; s.o.rw = 1'b1; s.o.rs = 2'b01; s.retire = 1'b1;
          plan.push_back(s);
        end
      end
      7'b0110011, 7'b0010011: begin
        plan.push_back(s);
        s = '0; s.o.a = 2'b10; s.o.op = 2'b10;
        if (w[4] && !w[5]) begin
          s.o.b = 2'b10; s.o.cc = {1'b0, w[14:12]};
        end else begin
          s.o.cc = {w[30], w[14:12]};
        end
        plan.push_back(s);
        s = '0; s.o.rw = 1'b1; s.retire = 1'b1;
        plan.push_back(s);
      end
      7'b1100011: begin
        plan.push_back(s);
        s = '0; s.br = 1'b1; s.o.a = 2'b10; s.o.op = 2'b01; s.o.pcs = 1'b1;
        if (w[14:13] != 2'b00) s.die = 1'b1;
        else s.retire = 1'b1;
        plan.push_back(s);
      end
      7'b1101111: begin
        plan.push_back(s);
        s = '0; s.o.rw = 1'b1; s.o.rs = 2'b10; s.o.pcw = 1'b1; s.o.pcs = 1'b1; s.retire = 1'b1;
        plan.push_back(s);
      end
      default: begin
        s.die = 1'b1;
        plan.push_back(s);
      end
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 9))
      0:       w[6:0] = 7'b0000011;
      1:       w[6:0] = 7'b0100011;
      2, 3:    w[6:0] = 7'b0110011;
      4, 9:    w[6:0] = 7'b0010011;
      5, 6: begin
        w[6:0] = 7'b1100011;
        if ($urandom_range(0, 7) != 0) w[14:13] = 2'b00;
      end
      7:       w[6:0] = 7'b1101111;
      default: ;
    endcase
    return w;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    if (!m_fault && plan.size() > 0) begin
      e = plan[0].o;
      if (plan[0].fetch && bus.mem_ready) begin
        e.irl = 1'b1;
        e.pcw = 1'b1;
      end
      if (plan[0].br)
        e.pcw = (bus.instr[14:12] == 3'b000) ? bus.zero :
                (bus.instr[14:12] == 3'b001) ? !bus.zero : 1'b0;
    end
    if (rst) begin
      e.req = 1'b0; e.we = 1'b0; e.irl = 1'b0; e.pcw = 1'b0; e.rw = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (run) begin
      e = expect_now();
      cmp("mem_req", bus.mem_req, e.req);
      cmp("mem_we", bus.mem_we, e.we);
      cmp("iord", bus.iord, e.iord);
      cmp("ir_load", bus.ir_load, e.irl);
      cmp("pc_write", bus.pc_write, e.pcw);
      cmp("pc_src", bus.pc_src, e.pcs);
      cmp("alu_src_a", bus.alu_src_a, e.a);
      cmp("alu_src_b", bus.alu_src_b, e.b);
      cmp("aluop", bus.aluop, e.op);
      cmp("ctrl_code", bus.ctrl_code, e.cc);
      cmp("reg_write", bus.reg_write, e.rw);
      cmp("result_src", bus.result_src, e.rs);
      cmp("retired", bus.retired, m_ret);
      cmp("fault", bus.fault, m_fault);
      cmp("fault_cause", bus.fault_cause, m_cause);
    end
  end

  task automatic drv(input logic r, input logic mr, input logic z);
    rst           = r;
    bus.mem_ready = mr;
    bus.zero      = z;
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // Clock edge: advance the model with the inputs the DUT sampled, then load a new IR if due.
  task automatic tick();
    logic [31:0] w;
    @(posedge clk);
    if (rst) begin
      plan.delete();
      m_fault = 1'b0; m_cause = 2'b00; m_ret = '0; m_wait = 0;
    end else if (!m_fault && plan.size() > 0) begin
      if (plan[0].mem && !bus.mem_ready) begin
        m_wait++;
        if (m_wait == TMO) begin
          m_fault = 1'b1; m_cause = 2'b10; m_wait = 0;
          plan.delete();
        end
      end else begin
        m_wait = 0;
        if (plan[0].retire) m_ret++;
        if (plan[0].die) begin
          m_fault = 1'b1; m_cause = 2'b01;
          plan.delete();
        end else begin
          void'(plan.pop_front());
        end
      end
    end
    #1;
    if (!m_fault && plan.size() == 0) begin
      w = use_dir ? dir_instr : rand_instr();
      bus.instr = w;
      build_plan(w);
    end
  endtask

  initial begin
    bus.instr = 32'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    m_fault = 1'b0; m_cause = 2'b00; m_ret = '0; m_wait = 0;
    use_dir = 1'b1; dir_instr = AddiW;

    drv(1'b1, 1'b1, 1'b0);
    tick();
    run = 1'b1;
    sync();
    cmp("rst_mem_req", bus.mem_req, 32'd0);
    cmp("rst_retired", bus.retired, 32'd0);
    cmp("rst_fault", bus.fault, 32'd0);
    tick();

    // addi: FETCH, DECODE, EXEC_I, ALU_WB
    drv(1'b0, 1'b1, 1'b0);
    sync(); cmp("addi_fetch_req", bus.mem_req, 32'd1);
    tick(); tick();
    sync(); cmp("addi_aluop", bus.aluop, 32'd2); cmp("addi_ctrl", bus.ctrl_code, 32'd0);
    tick();
    sync(); cmp("addi_wb_rw", bus.reg_write, 32'd1);
    dir_instr = SubW;
    tick();
    sync(); cmp("addi_retired", bus.retired, 32'd1); cmp("after_wb_rw", bus.reg_write, 32'd0);

    tick(); tick();
    sync(); cmp("sub_ctrl", bus.ctrl_code, 32'h8); cmp("sub_aluop", bus.aluop, 32'd2);
    dir_instr = SraiW;
    tick(); tick(); tick(); tick();
    sync(); cmp("srai_ctrl", bus.ctrl_code, 32'h5);

    // lw with three stalled cycles in MEM_RD
    dir_instr = LwW;
    tick(); tick(); tick(); tick(); tick();
    drv(1'b0, 1'b0, 1'b0);
    sync(); cmp("lw_rd_req", bus.mem_req, 32'd1); cmp("lw_rd_iord", bus.iord, 32'd1);
    tick(); tick(); tick();
    drv(1'b0, 1'b1, 1'b0);
    sync(); cmp("lw_rd_req_last", bus.mem_req, 32'd1);
    tick();
    sync(); cmp("lw_wb_rw", bus.reg_write, 32'd1); cmp("lw_wb_rs", bus.result_src, 32'd1);
    dir_instr = BeqW;
    tick();
    sync(); cmp("lw_retired", bus.retired, 32'd4);

    // beq taken, beq not taken, bne taken
    tick(); tick();
    drv(1'b0, 1'b1, 1'b1);
    sync(); cmp("beq_z1_pcw", bus.pc_write, 32'd1); cmp("beq_pcsrc", bus.pc_src, 32'd1);
    tick();
    drv(1'b0, 1'b1, 1'b0);
    tick(); tick();
    sync(); cmp("beq_z0_pcw", bus.pc_write, 32'd0);
    dir_instr = BneW;
    tick(); tick(); tick();
    sync(); cmp("bne_z0_pcw", bus.pc_write, 32'd1);

    // illegal opcode, then reset recovery
    dir_instr = BadW;
    tick(); tick(); tick();
    sync(); cmp("bad_fault", bus.fault, 32'd1); cmp("bad_cause", bus.fault_cause, 32'd1);
    cmp("bad_req", bus.mem_req, 32'd0);
    tick(); tick();
    sync(); cmp("bad_req_hold", bus.mem_req, 32'd0);
    drv(1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b0, 1'b1, 1'b0);
    sync(); cmp("recover_fault", bus.fault, 32'd0); cmp("recover_req", bus.mem_req, 32'd1);

    // fetch timeout after the fourth waiting cycle
    drv(1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    sync(); cmp("tmo_not_yet", bus.fault, 32'd0);
    tick();
    sync(); cmp("tmo_fault", bus.fault, 32'd1); cmp("tmo_cause", bus.fault_cause, 32'd2);

    // reset while a store waits for memory
    dir_instr = SwW;
    drv(1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b0, 1'b1, 1'b0);
    tick(); tick(); tick();
    drv(1'b0, 1'b0, 1'b0);
    sync(); cmp("sw_we", bus.mem_we, 32'd1);
    tick();
    drv(1'b1, 1'b0, 1'b0);
    sync(); cmp("sw_rst_we", bus.mem_we, 32'd0); cmp("sw_rst_req", bus.mem_req, 32'd0);
    tick();
    drv(1'b0, 1'b0, 1'b0);
    sync(); cmp("sw_rst_retired", bus.retired, 32'd0); cmp("sw_rst_fetch", bus.alu_src_b, 32'd1);

    // randomized phase
    use_dir = 1'b0;
    begin
      int stall = 0;
      for (int i = 0; i < 6000; i++) begin
        logic r, mr;
        if (stall == 0 && $urandom_range(0, 149) == 0) stall = $urandom_range(2, 6);
        if (stall > 0) begin
          mr = 1'b0;
          stall--;
        end else begin
          mr = ($urandom_range(0, 3) != 0);
        end
        r = m_fault ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
        drv(r, mr, 1'($urandom_range(0, 1)));
        tick();
      end
    end
    sync();
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
